// File: rtl/id_exe_reg.sv
// ---------------------------------------------------------------------------
// id_exe_reg
//   Pipeline register between instruction decode and execute, with the
//   operand forwarding muxes that feed the ALU.
//
//   Inputs
//     Clk, Reset            rising-edge clock, synchronous active-high reset
//     Stall                 hold the stage contents, ignore the ID inputs
//     Flush                 load a bubble instead of the ID instruction
//     ID_*                  decoded operands, register numbers and controls
//     MEM_Rw/RegWr/Result   producer sitting in the EX/MEM register
//     WB_Rw/RegWr/Data      producer sitting in the MEM/WB register
//   Outputs
//     EXE_BusA, EXE_B       forwarded ALU operands
//     EXE_BusB_Fwd          forwarded BusB (store data)
//     EXE_ALUctr, EXE_RegWr_Org, EXE_MemWr, EXE_MemtoReg, EXE_Rw
//                           stored control, write enables gated by valid
//     EXE_Valid             stage holds a real instruction
// ---------------------------------------------------------------------------
module id_exe_reg (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic [31:0] ID_BusA,
    input  logic [31:0] ID_BusB,
    input  logic [31:0] ID_Imm32,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  ID_Rw,
    input  logic [2:0]  ID_ALUctr,
    input  logic        ID_ALUSrc,
    input  logic        ID_RegWr,
    input  logic        ID_MemWr,
    input  logic        ID_MemtoReg,
    input  logic [4:0]  MEM_Rw,
    input  logic        MEM_RegWr,
    input  logic [31:0] MEM_Result,
    input  logic [4:0]  WB_Rw,
    input  logic        WB_RegWr,
    input  logic [31:0] WB_Data,
    output logic [31:0] EXE_BusA,
    output logic [31:0] EXE_B,
    output logic [31:0] EXE_BusB_Fwd,
    output logic [2:0]  EXE_ALUctr,
    output logic        EXE_RegWr_Org,
    output logic        EXE_MemWr,
    output logic        EXE_MemtoReg,
    output logic [4:0]  EXE_Rw,
    output logic        EXE_Valid
);

    logic [31:0] r_busa_p0;
    logic [31:0] r_busb_p0;
    logic [31:0] r_imm_p0;
    logic [4:0]  r_rs_p0;
    logic [4:0]  r_rt_p0;
    logic [4:0]  r_rw_p0;
    logic [2:0]  r_aluctr_p0;
    logic        r_alusrc_p0;
    logic        r_regwr_p0;
    logic        r_memwr_p0;
    logic        r_memtoreg_p0;
    logic        r_vld_p0;

    logic [31:0] w_busa_fwd;
    logic [31:0] w_busb_fwd;

    // Forwarding select: the MEM producer is younger than WB, so it wins
    // when both target the same register. Register 0 is hard-wired zero in
    // the register file and must never pick up a forwarded value.
    function automatic logic [31:0] fwd_sel(
        input logic [31:0] stored,
        input logic [4:0]  src,
        input logic [4:0]  mem_rw,
        input logic        mem_regwr,
        input logic [31:0] mem_result,
        input logic [4:0]  wb_rw,
        input logic        wb_regwr,
        input logic [31:0] wb_data
    );
        logic [31:0] result;
        result = stored;
        if (mem_regwr && (mem_rw != 5'd0) && (mem_rw == src))
            result = mem_result;
        else if (wb_regwr && (wb_rw != 5'd0) && (wb_rw == src))
            result = wb_data;
        return result;
    endfunction

    // ---- ID -> EXE stage register ----
    // Flush only has to kill the controls and the valid bit; the data
    // registers keep tracking ID so the datapath enables stay simple.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_busa_p0     <= 32'd0;
            r_busb_p0     <= 32'd0;
            r_imm_p0      <= 32'd0;
            r_rs_p0       <= 5'd0;
            r_rt_p0       <= 5'd0;
            r_rw_p0       <= 5'd0;
            r_aluctr_p0   <= 3'b000;
            r_alusrc_p0   <= 1'b0;
            r_regwr_p0    <= 1'b0;
            r_memwr_p0    <= 1'b0;
            r_memtoreg_p0 <= 1'b0;
            r_vld_p0      <= 1'b0;
        end else if (Flush) begin
            r_busa_p0     <= ID_BusA;
            r_busb_p0     <= ID_BusB;
            r_imm_p0      <= ID_Imm32;
            r_rs_p0       <= ID_Rs;
            r_rt_p0       <= ID_Rt;
            r_rw_p0       <= 5'd0;
            r_aluctr_p0   <= 3'b000;
            r_alusrc_p0   <= 1'b0;
            r_regwr_p0    <= 1'b0;
            r_memwr_p0    <= 1'b0;
            r_memtoreg_p0 <= 1'b0;
            r_vld_p0      <= 1'b0;
        end else if (!Stall) begin
            r_busa_p0     <= ID_BusA;
            r_busb_p0     <= ID_BusB;
            r_imm_p0      <= ID_Imm32;
            r_rs_p0       <= ID_Rs;
            r_rt_p0       <= ID_Rt;
            r_rw_p0       <= ID_Rw;
            r_aluctr_p0   <= ID_ALUctr;
            r_alusrc_p0   <= ID_ALUSrc;
            r_regwr_p0    <= ID_RegWr;
            r_memwr_p0    <= ID_MemWr;
            r_memtoreg_p0 <= ID_MemtoReg;
            r_vld_p0      <= 1'b1;
        end
    end

    // ---- EXE combinational forwarding ----
    assign w_busa_fwd = fwd_sel(r_busa_p0, r_rs_p0, MEM_Rw, MEM_RegWr, MEM_Result,
                                WB_Rw, WB_RegWr, WB_Data);
    assign w_busb_fwd = fwd_sel(r_busb_p0, r_rt_p0, MEM_Rw, MEM_RegWr, MEM_Result,
                                WB_Rw, WB_RegWr, WB_Data);

    assign EXE_BusA      = w_busa_fwd;
    assign EXE_BusB_Fwd  = w_busb_fwd;
    assign EXE_B         = r_alusrc_p0 ? r_imm_p0 : w_busb_fwd;
    assign EXE_ALUctr    = r_aluctr_p0;
    // Write enables are qualified by valid so a bubble can never commit.
    assign EXE_RegWr_Org = r_regwr_p0 & r_vld_p0;
    assign EXE_MemWr     = r_memwr_p0 & r_vld_p0;
    assign EXE_MemtoReg  = r_memtoreg_p0;
    assign EXE_Rw        = r_rw_p0;
    assign EXE_Valid     = r_vld_p0;

endmodule

// File: tb/tb_id_exe_reg.sv
module tb_id_exe_reg;

    logic        Clk = 1'b0;
    logic        Reset, Stall, Flush;
    logic [31:0] ID_BusA, ID_BusB, ID_Imm32;
    logic [4:0]  ID_Rs, ID_Rt, ID_Rw;
    logic [2:0]  ID_ALUctr;
    logic        ID_ALUSrc, ID_RegWr, ID_MemWr, ID_MemtoReg;
    logic [4:0]  MEM_Rw;
    logic        MEM_RegWr;
    logic [31:0] MEM_Result;
    logic [4:0]  WB_Rw;
    logic        WB_RegWr;
    logic [31:0] WB_Data;
    logic [31:0] EXE_BusA, EXE_B, EXE_BusB_Fwd;
    logic [2:0]  EXE_ALUctr;
    logic        EXE_RegWr_Org, EXE_MemWr, EXE_MemtoReg;
    logic [4:0]  EXE_Rw;
    logic        EXE_Valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [107:0] v;
        logic [107:0] m;
    } exp_t;

    exp_t exp_q[$];

    localparam logic [107:0] MASK_ALL  = {108{1'b1}};
    localparam logic [107:0] MASK_CTRL = {96'd0, 12'hFFF};

    id_exe_reg dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
        .ID_BusA(ID_BusA), .ID_BusB(ID_BusB), .ID_Imm32(ID_Imm32),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rw(ID_Rw),
        .ID_ALUctr(ID_ALUctr), .ID_ALUSrc(ID_ALUSrc), .ID_RegWr(ID_RegWr),
        .ID_MemWr(ID_MemWr), .ID_MemtoReg(ID_MemtoReg),
        .MEM_Rw(MEM_Rw), .MEM_RegWr(MEM_RegWr), .MEM_Result(MEM_Result),
        .WB_Rw(WB_Rw), .WB_RegWr(WB_RegWr), .WB_Data(WB_Data),
        .EXE_BusA(EXE_BusA), .EXE_B(EXE_B), .EXE_BusB_Fwd(EXE_BusB_Fwd),
        .EXE_ALUctr(EXE_ALUctr), .EXE_RegWr_Org(EXE_RegWr_Org),
        .EXE_MemWr(EXE_MemWr), .EXE_MemtoReg(EXE_MemtoReg),
        .EXE_Rw(EXE_Rw), .EXE_Valid(EXE_Valid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [107:0] pack(
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] bf,
        input logic [2:0] ctr, input logic rw_en, input logic mw,
        input logic m2r, input logic [4:0] rw, input logic vld
    );
        return {a, b, bf, ctr, rw_en, mw, m2r, rw, vld};
    endfunction

    function automatic logic [107:0] observed();
        return pack(EXE_BusA, EXE_B, EXE_BusB_Fwd, EXE_ALUctr, EXE_RegWr_Org,
                    EXE_MemWr, EXE_MemtoReg, EXE_Rw, EXE_Valid);
    endfunction

    task automatic push(input logic [107:0] v, input logic [107:0] m);
        exp_t e;
        e.v = v;
        e.m = m;
        exp_q.push_back(e);
    endtask

    task automatic set_id(
        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
        input logic [2:0] ctr, input logic alusrc, input logic regwr,
        input logic memwr, input logic m2r
    );
        ID_BusA = a; ID_BusB = b; ID_Imm32 = imm;
        ID_Rs = rs; ID_Rt = rt; ID_Rw = rw; ID_ALUctr = ctr;
        ID_ALUSrc = alusrc; ID_RegWr = regwr; ID_MemWr = memwr; ID_MemtoReg = m2r;
    endtask

    task automatic fwd_off();
        MEM_Rw = 5'd0; MEM_RegWr = 1'b0; MEM_Result = 32'd0;
        WB_Rw = 5'd0; WB_RegWr = 1'b0; WB_Data = 32'd0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [107:0] obs;
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        fwd_off();
        set_id(32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 5'd1, 5'd2, 5'd3,
               3'b111, 1'b1, 1'b1, 1'b1, 1'b1);
        push(pack(0, 0, 0, 0, 0, 0, 0, 0, 0), MASK_ALL);
        @(posedge Clk); #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL reset got=%h want=%h", obs, e.v);
        end
        Reset = 1'b0;
    endtask

    task automatic test_load();
        exp_t e;
        logic [107:0] obs;
        set_id(32'd5, 32'd7, 32'h1234, 5'd1, 5'd2, 5'd3, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        push(pack(32'd5, 32'd7, 32'd7, 3'b010, 1, 0, 0, 5'd3, 1), MASK_ALL);
        @(posedge Clk); #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL load got=%h want=%h", obs, e.v);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [107:0] obs;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id($urandom, $urandom, $urandom, 5'($urandom_range(1, 31)),
                   5'($urandom_range(1, 31)), 5'($urandom), 3'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            push(pack(32'd5, 32'd7, 32'd7, 3'b010, 1, 0, 0, 5'd3, 1), MASK_ALL);
            @(posedge Clk); #1;
            obs = observed();
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL stall cycle=%0d got=%h want=%h", i, obs, e.v);
            end
        end
    endtask

    task automatic test_flush_stall();
        exp_t e;
        logic [107:0] obs;
        Stall = 1'b1; Flush = 1'b1;
        set_id(32'hAA, 32'hBB, 32'hCC, 5'd1, 5'd2, 5'd9, 3'b101, 1'b1, 1'b1, 1'b1, 1'b1);
        push(pack(0, 0, 0, 3'b000, 0, 0, 0, 5'd0, 0), MASK_CTRL);
        @(posedge Clk); #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL flush_stall got=%h want=%h", obs & e.m, e.v & e.m);
        end
        Stall = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_fwd_priority();
        exp_t e;
        logic [107:0] obs;
        MEM_RegWr = 1'b1; MEM_Rw = 5'd4; MEM_Result = 32'h100;
        WB_RegWr = 1'b1; WB_Rw = 5'd4; WB_Data = 32'h200;
        set_id(32'h55, 32'h66, 32'h77, 5'd4, 5'd6, 5'd9, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        push(pack(32'h100, 32'h66, 32'h66, 3'b001, 1, 0, 0, 5'd9, 1), MASK_ALL);
        @(posedge Clk); #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL fwd_mem_over_wb got=%h want=%h", obs, e.v);
        end
        // Hold the stage so only the producer inputs move the outputs.
        Stall = 1'b1;
        MEM_RegWr = 1'b0;
        push(pack(32'h200, 32'h66, 32'h66, 3'b001, 1, 0, 0, 5'd9, 1), MASK_ALL);
        #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL fwd_wb got=%h want=%h", obs, e.v);
        end
        WB_RegWr = 1'b0;
        push(pack(32'h55, 32'h66, 32'h66, 3'b001, 1, 0, 0, 5'd9, 1), MASK_ALL);
        #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL fwd_none got=%h want=%h", obs, e.v);
        end
        WB_RegWr = 1'b1; WB_Rw = 5'd6;
        push(pack(32'h55, 32'h200, 32'h200, 3'b001, 1, 0, 0, 5'd9, 1), MASK_ALL);
        #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL fwd_wb_rt got=%h want=%h", obs, e.v);
        end
        Stall = 1'b0;
        fwd_off();
    endtask

    task automatic test_rt_zero();
        exp_t e;
        logic [107:0] obs;
        MEM_RegWr = 1'b1; MEM_Rw = 5'd0; MEM_Result = 32'h999;
        WB_RegWr = 1'b1; WB_Rw = 5'd0; WB_Data = 32'h888;
        set_id(32'h22, 32'h11, 32'h0, 5'd0, 5'd0, 5'd2, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0);
        push(pack(32'h22, 32'h11, 32'h11, 3'b011, 1, 0, 0, 5'd2, 1), MASK_ALL);
        @(posedge Clk); #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL r0_no_fwd got=%h want=%h", obs, e.v);
        end
        fwd_off();
    endtask

    task automatic test_alusrc_imm();
        exp_t e;
        logic [107:0] obs;
        MEM_RegWr = 1'b1; MEM_Rw = 5'd7; MEM_Result = 32'hDEAD0001;
        set_id(32'h44, 32'h33, 32'hFFFFFFFC, 5'd3, 5'd7, 5'd0, 3'b110, 1'b1, 1'b0, 1'b1, 1'b1);
        push(pack(32'h44, 32'hFFFFFFFC, 32'hDEAD0001, 3'b110, 0, 1, 1, 5'd0, 1), MASK_ALL);
        @(posedge Clk); #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL alusrc_imm got=%h want=%h", obs, e.v);
        end
        fwd_off();
    endtask

    task automatic test_reset_mid_stall();
        exp_t e;
        logic [107:0] obs;
        set_id(32'h1111, 32'h2222, 32'h3333, 5'd8, 5'd9, 5'd5, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0);
        push(pack(32'h1111, 32'h2222, 32'h2222, 3'b100, 1, 1, 0, 5'd5, 1), MASK_ALL);
        @(posedge Clk); #1;
        Stall = 1'b1;
        set_id(32'h9, 32'h9, 32'h9, 5'd1, 5'd1, 5'd1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1);
        push(pack(32'h1111, 32'h2222, 32'h2222, 3'b100, 1, 1, 0, 5'd5, 1), MASK_ALL);
        @(posedge Clk); #1;
        for (int i = 0; i < 2; i++) begin
            obs = observed();
            if (i == 0) begin
                // First entry was the load; both should match the held state.
                e = exp_q.pop_front();
            end else begin
                e = exp_q.pop_front();
            end
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL held_before_reset idx=%0d got=%h want=%h", i, obs, e.v);
            end
        end
        Reset = 1'b1; Flush = 1'b1;
        push(pack(0, 0, 0, 0, 0, 0, 0, 0, 0), MASK_ALL);
        @(posedge Clk); #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL reset_mid_stall got=%h want=%h", obs, e.v);
        end
        Reset = 1'b0; Flush = 1'b0; Stall = 1'b0;
        set_id(32'hCAFE, 32'hBEEF, 32'h0, 5'd10, 5'd11, 5'd12, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        push(pack(32'hCAFE, 32'hBEEF, 32'hBEEF, 3'b010, 1, 0, 0, 5'd12, 1), MASK_ALL);
        @(posedge Clk); #1;
        obs = observed();
        e = exp_q.pop_front();
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
            errors++;
            $display("FAIL load_after_reset got=%h want=%h", obs, e.v);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [107:0] obs;
        logic [31:0] a, b, imm;
        logic [4:0]  rw;
        logic [2:0]  ctr;
        logic        src, rwe, mw, m2r;
        for (int i = 0; i < 8; i++) begin
            a = $urandom; b = $urandom; imm = $urandom;
            rw = 5'($urandom); ctr = 3'($urandom);
            src = 1'($urandom); rwe = 1'($urandom); mw = 1'($urandom); m2r = 1'($urandom);
            set_id(a, b, imm, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
                   rw, ctr, src, rwe, mw, m2r);
            push(pack(a, src ? imm : b, b, ctr, rwe, mw, m2r, rw, 1), MASK_ALL);
            @(posedge Clk); #1;
            obs = observed();
            e = exp_q.pop_front();
            checks++;
            if ((obs & e.m) !== (e.v & e.m)) begin
                errors++;
                $display("FAIL back_to_back idx=%0d got=%h want=%h", i, obs, e.v);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; Stall = 1'b0; Flush = 1'b0;
        fwd_off();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge Clk); #1;
        test_reset();
        test_load();
        test_stall();
        test_flush_stall();
        test_fwd_priority();
        test_rt_zero();
        test_alusrc_imm();
        test_reset_mid_stall();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high; clears all pipeline state.
REQ-004 Stall  input  1  hold current contents; ignore ID inputs.
REQ-005 Flush  input  1  load a bubble (NOP) instead of ID inputs.
REQ-006 ID_BusA, ID_BusB, ID_Imm32  input  32 each  register operands and extended immediate from decode.
REQ-007 ID_Rs, ID_Rt, ID_Rw  input  5 each  source and destination register numbers.
REQ-008 ID_ALUctr  input  3  ALU operation code.
REQ-009 ID_ALUSrc, ID_RegWr, ID_MemWr, ID_MemtoReg  input  1 each  decode control bits.
REQ-010 MEM_Rw  input  5; MEM_RegWr  input  1; MEM_Result  input  32  EX/MEM producer for forwarding.
REQ-011 WB_Rw  input  5; WB_RegWr  input  1; WB_Data  input  32  MEM/WB producer for forwarding.
REQ-012 EXE_BusA, EXE_B  output  32 each  forwarded ALU operands to the execute stage.
REQ-013 EXE_BusB_Fwd  output  32  forwarded BusB, the store data for memory.
REQ-014 EXE_ALUctr  output  3; EXE_RegWr_Org  output  1; EXE_MemWr, EXE_MemtoReg  output  1 each; EXE_Rw  output  5.
REQ-015 EXE_Valid  output  1  stage holds a real instruction (0 = bubble).

Function
REQ-016 Priority at each rising Clk edge SHALL be Reset > Flush > Stall > normal load.
REQ-017 On normal load, every ID_* input SHALL be captured into the matching stage register, and Valid SHALL be set to 1; latency from ID input to EXE output is exactly one cycle.
REQ-018 While Stall=1 and Flush=0, all stage registers, including Valid, SHALL hold their values.
REQ-019 Flush=1 SHALL load a bubble: all control bits 0, ALUctr 3'b000, Rw 0, Valid 0; data registers may load ID values. This applies even when Stall=1.
REQ-020 EXE_RegWr_Org and EXE_MemWr SHALL be gated by Valid, so a bubble never writes.
REQ-021 A forward of operand A from MEM SHALL occur when MEM_RegWr=1, MEM_Rw!=0 and MEM_Rw==stored Rs.
REQ-022 Otherwise, a forward of operand A from WB SHALL occur when WB_RegWr=1, WB_Rw!=0 and WB_Rw==stored Rs; otherwise the stored BusA is used.
REQ-023 Operand B forwarding SHALL use the same rule with stored Rt and SHALL produce EXE_BusB_Fwd.
REQ-024 When both MEM and WB match the same register, MEM SHALL win (most recent producer).
REQ-025 EXE_B SHALL equal the stored Imm32 when ALUSrc=1, else EXE_BusB_Fwd.
REQ-026 Forwarding muxes SHALL be combinational from the stored registers and the MEM/WB inputs, with no extra cycle.
REQ-027 Register 0 SHALL never be forwarded; a source of Rs/Rt=0 SHALL read the stored bus value.
REQ-028 The block SHALL hold no other state; a stall of N cycles SHALL keep the outputs constant, except for forwarding changes driven by MEM/WB inputs.

Reset
REQ-029 Reset=1 at a rising edge SHALL clear all stage registers to 0: outputs EXE_ALUctr=3'b000, EXE_RegWr_Org=0, EXE_MemWr=0, EXE_MemtoReg=0, EXE_Rw=0, EXE_Valid=0, stored data 0.
REQ-030 Reset SHALL override concurrent Flush and Stall, including when asserted mid-stall.
REQ-031 After Reset deasserts, the first edge with Stall=0 SHALL load the ID inputs normally.

Verification
REQ-032 Load: ID_BusA=5, ID_BusB=7, ALUSrc=0, RegWr=1, Rw=3 -> next cycle EXE_BusA=5, EXE_B=7, EXE_RegWr_Org=1, EXE_Rw=3, EXE_Valid=1.
REQ-033 Stall for 3 cycles while the ID inputs change -> outputs unchanged. Then Flush+Stall together -> next cycle EXE_RegWr_Org=0, EXE_MemWr=0, EXE_Valid=0.
REQ-034 Stored Rs=4, MEM_RegWr=1, MEM_Rw=4, MEM_Result=0x100, WB_RegWr=1, WB_Rw=4, WB_Data=0x200 -> EXE_BusA=0x100. Drop MEM_RegWr -> EXE_BusA=0x200.
REQ-035 Stored Rt=0, MEM_Rw=0, MEM_RegWr=1, stored BusB=0x11 -> EXE_BusB_Fwd=0x11, no forward.
REQ-036 ALUSrc=1, Imm32=0xFFFFFFFC, Rt forward active -> EXE_B=0xFFFFFFFC, EXE_BusB_Fwd=forwarded value.
REQ-037 Reset asserted during a stall with a valid instruction held -> next cycle all outputs 0, EXE_Valid=0.
